// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, kernel constants and padding helper for the conv_same sequencer
package conv_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  localparam int KSIZE = 9;
  localparam logic [KSIZE-1:0][7:0] TAP_ORDER = {8'h33, 8'h32, 8'h31, 8'h23, 8'h22, 8'h21, 8'h13, 8'h12, 8'h11};
  function automatic int padded_rows(input int img_h);
    return img_h + 2;
  endfunction
endpackage

// File: rtl/conv_same_addr_gen.sv
// conv_same_addr_gen: padded row/column walk and feature-map read address
module conv_same_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int FM_AW = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             clear,
  output logic             pad,
  output logic             last,
  output logic [FM_AW-1:0] addr
);
  localparam int ROWS = padded_rows(IMG_H);
  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(IMG_W + 1);
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [FM_AW-1:0] base;
  logic eol;
  assign eol = c == CW'(IMG_W - 1);
  assign pad = r == '0 || r == RW'(ROWS - 1);
  assign last = eol && r == RW'(ROWS - 1);
  assign addr = step && !pad ? base + FM_AW'(c) : '0;
  // base tracks (r-1)*IMG_W: it only advances when leaving an image row
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r <= '0;
      c <= '0;
      base <= '0;
    end else if (clear) begin
      r <= '0;
      c <= '0;
      base <= '0;
    end else if (step) begin
      c <= eol ? '0 : c + 1'b1;
      r <= eol ? r + 1'b1 : r;
      base <= eol && !pad ? base + FM_AW'(IMG_W) : base;
    end
endmodule

// File: rtl/conv_same_ctrl.sv
// conv_same_ctrl: per-kernel weight load, padded feature-map stream and drain sequencing
module conv_same_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int OUT_CH = 4,
  parameter int FM_AW = 14,
  parameter int W_AW = 8,
  parameter int DRAIN_CYC = 140,
  localparam int OCW = OUT_CH > 1 ? $clog2(OUT_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [OCW-1:0]    oc_idx,
  output logic              w_rd_en,
  output logic [W_AW-1:0]   w_rd_addr,
  input  logic signed [7:0] w_rd_data,
  output logic              fm_rd_en,
  output logic [FM_AW-1:0]  fm_rd_addr,
  input  logic signed [7:0] fm_rd_data,
  output logic signed [7:0] weight_11,
  output logic signed [7:0] weight_12,
  output logic signed [7:0] weight_13,
  output logic signed [7:0] weight_21,
  output logic signed [7:0] weight_22,
  output logic signed [7:0] weight_23,
  output logic signed [7:0] weight_31,
  output logic signed [7:0] weight_32,
  output logic signed [7:0] weight_33,
  output logic              conv_valid_in,
  output logic signed [7:0] conv_din
);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  state_t state, nxt;
  logic [3:0] k;
  logic [DW-1:0] d;
  logic pad, last, pad_d;
  logic signed [7:0] kern [KSIZE];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD_W : IDLE;
      LOAD_W:  nxt = k == 4'(KSIZE) ? STREAM : LOAD_W;
      STREAM:  nxt = last ? DRAIN : STREAM;
      DRAIN:   nxt = d == DW'(DRAIN_CYC) ? (oc_idx == OCW'(OUT_CH - 1) ? DONE : LOAD_W) : DRAIN;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign w_rd_en = state == LOAD_W && k < 4'(KSIZE);
  assign w_rd_addr = w_rd_en ? W_AW'(oc_idx) * W_AW'(KSIZE) + W_AW'(k) : '0;
  assign fm_rd_en = state == STREAM && !pad;
  assign conv_din = conv_valid_in && !pad_d ? fm_rd_data : '0;
  conv_same_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .FM_AW(FM_AW)) u_addr (
    .clk(clk),
    .rst(rst),
    .step(state == STREAM),
    .clear(nxt != STREAM),
    .pad(pad),
    .last(last),
    .addr(fm_rd_addr)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      k <= '0;
      d <= '0;
      oc_idx <= '0;
      conv_valid_in <= 1'b0;
      pad_d <= 1'b0;
    end else begin
      k <= state == LOAD_W && nxt == LOAD_W ? k + 1'b1 : '0;
      d <= state == DRAIN && nxt == DRAIN ? d + 1'b1 : '0;
      oc_idx <= nxt == IDLE ? '0 : state == DRAIN && nxt == LOAD_W ? oc_idx + 1'b1 : oc_idx;
      conv_valid_in <= state == STREAM && nxt != IDLE;
      pad_d <= pad;
    end
  // read data for tap k-1 arrives while k is on the next address
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < KSIZE; i++) kern[i] <= '0;
    else if (state == LOAD_W && k != '0) kern[k - 1'b1] <= w_rd_data;
  assign weight_11 = kern[0];
  assign weight_12 = kern[1];
  assign weight_13 = kern[2];
  assign weight_21 = kern[3];
  assign weight_22 = kern[4];
  assign weight_23 = kern[5];
  assign weight_31 = kern[6];
  assign weight_32 = kern[7];
  assign weight_33 = kern[8];
endmodule

// File: tb/tb_conv_same_ctrl.sv
// tb_conv_same_ctrl: directed checks of the conv_same sequencer on a 4x3 image, two kernels
module tb_conv_same_ctrl;
  localparam int EXP_BUSY = 2 * (10 + 20 + 1 + 6) + 1;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic busy, done, w_rd_en, fm_rd_en, conv_valid_in;
  logic [0:0] oc_idx;
  logic [4:0] w_rd_addr;
  logic [3:0] fm_rd_addr;
  logic signed [7:0] w_rd_data, fm_rd_data, conv_din;
  logic signed [7:0] weight_11, weight_12, weight_13, weight_21, weight_22, weight_23, weight_31, weight_32, weight_33;
  logic signed [7:0] w_mem [32];
  logic signed [7:0] fm_mem [16];
  int n_vec = 0, n_err = 0;
  int cyc = 0, busy_cnt = 0, done_cnt = 0, wchg = 0, run_len = 0;
  int din_q[$], oc_q[$], run_q[$];
  logic [71:0] ks_q[$];
  logic prev_v = 1'b0;
  logic [71:0] last_w = '0, cur_w;

  conv_same_ctrl #(.IMG_W(4), .IMG_H(3), .OUT_CH(2), .FM_AW(4), .W_AW(5), .DRAIN_CYC(6)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done), .oc_idx(oc_idx),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .fm_rd_data(fm_rd_data),
    .weight_11(weight_11), .weight_12(weight_12), .weight_13(weight_13),
    .weight_21(weight_21), .weight_22(weight_22), .weight_23(weight_23),
    .weight_31(weight_31), .weight_32(weight_32), .weight_33(weight_33),
    .conv_valid_in(conv_valid_in), .conv_din(conv_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= w_mem[w_rd_addr];
    if (fm_rd_en) fm_rd_data <= fm_mem[fm_rd_addr];
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    cur_w = {weight_11, weight_12, weight_13, weight_21, weight_22, weight_23, weight_31, weight_32, weight_33};
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (conv_valid_in) begin
      din_q.push_back(int'(conv_din));
      if (!prev_v) begin
        ks_q.push_back(cur_w);
        oc_q.push_back(int'(oc_idx));
      end else if (cur_w != last_w) wchg++;
      run_len++;
    end else if (prev_v) begin
      run_q.push_back(run_len);
      run_len = 0;
    end
    prev_v = conv_valid_in;
    last_w = cur_w;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic int kw(input logic [71:0] v, input int j);
    logic signed [7:0] b;
    b = v[71-8*j -: 8];
    return int'(b);
  endfunction

  task automatic run_full(input string tag, input bit mid_start);
    int b0, d0, q0, k0, r0, w0, n;
    b0 = busy_cnt; d0 = done_cnt; q0 = din_q.size(); k0 = ks_q.size(); r0 = run_q.size(); w0 = wchg;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_t1"}, int'(busy), 1);
    chk({tag, "_wen_t1"}, int'(w_rd_en), 1);
    chk({tag, "_waddr_t1"}, int'(w_rd_addr), 0);
    n = 1;
    while (!conv_valid_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_first_valid"}, n, 12);
    if (mid_start) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, int'(done), 1);
    repeat (3) @(negedge clk);
    chk({tag, "_busy_cycles"}, busy_cnt - b0, EXP_BUSY);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_runs"}, run_q.size() - r0, 2);
    for (int i = r0; i < run_q.size(); i++) chk({tag, "_run_len"}, run_q[i], 20);
    chk({tag, "_din_count"}, din_q.size() - q0, 40);
    for (int i = 0; i < 40 && q0 + i < din_q.size(); i++)
      chk({tag, "_din"}, din_q[q0+i], (i % 20 < 4 || i % 20 >= 16) ? 0 : i % 20 - 3);
    chk({tag, "_kernels"}, ks_q.size() - k0, 2);
    for (int p = 0; p < 2 && k0 + p < ks_q.size(); p++) begin
      chk({tag, "_oc"}, oc_q[k0+p], p);
      for (int j = 0; j < 9; j++) chk({tag, "_weight"}, kw(ks_q[k0+p], j), int'(w_mem[p*9+j]));
    end
    chk({tag, "_weights_stable"}, wchg - w0, 0);
  endtask

  initial begin
    int n, d0;
    for (int i = 0; i < 32; i++) w_mem[i] = 8'(i);
    for (int i = 0; i < 16; i++) fm_mem[i] = 8'(i + 1);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(conv_valid_in), 0);
    chk("rst_wen", int'(w_rd_en), 0);
    chk("rst_fmen", int'(fm_rd_en), 0);
    chk("rst_w11", int'(weight_11), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_oc", int'(oc_idx), 0);
    chk("idle_din", int'(conv_din), 0);

    run_full("basic", 1'b0);
    chk("basic_w11_k0", kw(ks_q[0], 0), 0);
    chk("basic_w33_k1", kw(ks_q[1], 8), 17);

    run_full("midstart", 1'b1);

    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(conv_valid_in), 0);
    chk("abort_fmen", int'(fm_rd_en), 0);
    chk("abort_oc", int'(oc_idx), 0);
    repeat (5) @(negedge clk);
    chk("abort_run_len", run_q[run_q.size()-1], 4);
    chk("abort_no_done", done_cnt - d0, 0);
    run_full("after_abort", 1'b0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!conv_valid_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (conv_valid_in && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("pre_rst_w33", int'(weight_33), 8);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_w33", int'(weight_33), 0);
    chk("mid_rst_w11", int'(weight_11), 0);
    chk("mid_rst_oc", int'(oc_idx), 0);
    chk("mid_rst_valid", int'(conv_valid_in), 0);
    chk("mid_rst_din", int'(conv_din), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_full("after_rst", 1'b0);

    w_mem[0] = -8'sd128;
    w_mem[1] = 8'sd127;
    run_full("signed", 1'b0);
    chk("signed_w11", kw(ks_q[ks_q.size()-2], 0), -128);
    chk("signed_w12", kw(ks_q[ks_q.size()-2], 1), 127);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
